// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared opcodes, ALU op codes, FSM states and flag indices
//               for param_exec_core.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam logic [3:0] OP_MVR = 4'b0000;
    localparam logic [3:0] OP_LDB = 4'b0001;
    localparam logic [3:0] OP_STB = 4'b0010;
    localparam logic [3:0] OP_RDS = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b1001;
    localparam logic [3:0] OP_ORA = 4'b1010;
    localparam logic [3:0] OP_ADD = 4'b1011;
    localparam logic [3:0] OP_SUB = 4'b1100;
    localparam logic [3:0] OP_XOR = 4'b1101;
    localparam logic [3:0] OP_INC = 4'b1110;

    // ALU codes are the low three opcode bits of the 1xxx group
    typedef enum logic [2:0] {
        ALU_NOT = 3'd0,
        ALU_AND = 3'd1,
        ALU_ORA = 3'd2,
        ALU_ADD = 3'd3,
        ALU_SUB = 3'd4,
        ALU_XOR = 3'd5,
        ALU_INC = 3'd6,
        ALU_NOP = 3'd7
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

endpackage
`default_nettype wire

// File: rtl/exec_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_if
// Description : Instruction handshake, result port and status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_if #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_op;
    logic [REG_ADDR_W-1:0] in_ra;
    logic [REG_ADDR_W-1:0] in_rb;
    logic [REG_ADDR_W-1:0] in_rc;
    logic [DATA_W-1:0]     in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [2:0]            flags;

    modport master (
        output in_valid, in_op, in_ra, in_rb, in_rc, in_imm, out_ready,
        input  in_ready, out_valid, out_data, flags
    );

    modport slave (
        input  in_valid, in_op, in_ra, in_rb, in_rc, in_imm, out_ready,
        output in_ready, out_valid, out_data, flags
    );
endinterface
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : exec_alu
// Description : Combinational DATA_W-bit ALU with carry/borrow output.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_in1,
    input  logic [DATA_W-1:0] i_in2,
    input  alu_op_e           i_op,
    output logic [DATA_W-1:0] o_out,
    output logic              o_c
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic [DATA_W:0] w_inc;

    // The extra MSB carries out of ADD/INC and is the borrow (in1 < in2) of SUB
    assign w_sum  = {1'b0, i_in1} + {1'b0, i_in2};
    assign w_diff = {1'b0, i_in1} - {1'b0, i_in2};
    assign w_inc  = {1'b0, i_in1} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        o_out = '0;
        o_c   = 1'b0;
        case (i_op)
            ALU_NOT: o_out = ~i_in1;
            ALU_AND: o_out = i_in1 & i_in2;
            ALU_ORA: o_out = i_in1 | i_in2;
            ALU_ADD: {o_c, o_out} = w_sum;
            ALU_SUB: {o_c, o_out} = w_diff;
            ALU_XOR: o_out = i_in1 ^ i_in2;
            ALU_INC: {o_c, o_out} = w_inc;
            ALU_NOP: o_out = '0;
            default: o_out = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/param_exec_core.sv
`default_nettype none
// ============================================================================
// Module      : param_exec_core
// Description : Parametrised execute core: register file, ALU, {N,Z,C} flags,
//               bit-serial shifter and a single-entry buffered output port.
// Revision    : 1.0 - initial release
// ============================================================================
module param_exec_core
    import exec_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_COUNT  = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic   clk,
    input  logic   rst,
    exec_if.slave  bus
);
    state_e                r_state;
    state_e                w_state_nxt;
    logic [DATA_W-1:0]     r_regs [REG_COUNT];
    logic [2:0]            r_flags;
    logic [2:0]            w_flags_nxt;
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_data;
    logic [DATA_W-1:0]     w_out_data_nxt;
    logic                  w_out_load;
    logic [DATA_W-1:0]     r_sh_data;
    logic [DATA_W-1:0]     w_sh_next;
    logic [REG_ADDR_W-1:0] r_sh_cnt;
    logic [REG_ADDR_W-1:0] r_sh_rd;
    logic                  r_sh_left;
    logic                  w_sh_bit;
    logic                  w_sh_start;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_rs1;
    logic [DATA_W-1:0]     w_rs2;
    logic [DATA_W-1:0]     w_alu_out;
    logic                  w_alu_c;
    logic                  w_wr_en;
    logic                  w_flag_en;
    logic                  w_c_nxt;
    logic [REG_ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0]     w_wr_data;

    assign w_in_ready    = !rst && (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept      = bus.in_valid && w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.flags     = r_flags;

    assign w_rs1 = r_regs[bus.in_rb];
    assign w_rs2 = r_regs[bus.in_rc];

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .i_in1 (w_rs1),
        .i_in2 (w_rs2),
        .i_op  (alu_op_e'(bus.in_op[2:0])),
        .o_out (w_alu_out),
        .o_c   (w_alu_c)
    );

    // One bit per SHIFT cycle; the carry is simply the bit leaving this step
    assign w_sh_next = r_sh_left ? {r_sh_data[DATA_W-2:0], 1'b0} : {1'b0, r_sh_data[DATA_W-1:1]};
    assign w_sh_bit  = r_sh_left ? r_sh_data[DATA_W-1] : r_sh_data[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_en        = 1'b0;
        w_wr_addr      = bus.in_ra;
        w_wr_data      = w_rs1;
        w_flag_en      = 1'b0;
        w_c_nxt        = 1'b0;
        w_out_load     = 1'b0;
        w_out_data_nxt = w_rs1;
        w_sh_start     = 1'b0;
        w_flags_nxt    = r_flags;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.in_op)
                        OP_MVR: w_wr_en = 1'b1;
                        OP_LDB: begin
                            w_wr_en   = 1'b1;
                            w_wr_data = bus.in_imm;
                        end
                        OP_STB: w_out_load = 1'b1;
                        OP_RDS: begin
                            w_out_load          = 1'b1;
                            w_out_data_nxt      = '0;
                            w_out_data_nxt[2:0] = r_flags;
                        end
                        OP_SHL, OP_SHR: begin
                            if (bus.in_rc == '0) begin
                                w_wr_en   = 1'b1;
                                w_flag_en = 1'b1;
                            end else begin
                                w_sh_start  = 1'b1;
                                w_state_nxt = ST_SHIFT;
                            end
                        end
                        OP_NOT, OP_AND, OP_ORA, OP_ADD, OP_SUB, OP_XOR, OP_INC: begin
                            w_wr_en   = 1'b1;
                            w_flag_en = 1'b1;
                            w_wr_data = w_alu_out;
                            w_c_nxt   = w_alu_c;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (r_sh_cnt == REG_ADDR_W'(1)) begin
                    w_wr_en     = 1'b1;
                    w_flag_en   = 1'b1;
                    w_wr_addr   = r_sh_rd;
                    w_wr_data   = w_sh_next;
                    w_c_nxt     = w_sh_bit;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_flag_en) begin
            w_flags_nxt[FLAG_N] = w_wr_data[DATA_W-1];
            w_flags_nxt[FLAG_Z] = (w_wr_data == '0);
            w_flags_nxt[FLAG_C] = w_c_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_data <= '0;
            r_sh_cnt  <= '0;
            r_sh_rd   <= '0;
            r_sh_left <= 1'b0;
        end else if (w_sh_start) begin
            r_sh_data <= w_rs1;
            r_sh_cnt  <= bus.in_rc;
            r_sh_rd   <= bus.in_ra;
            r_sh_left <= (bus.in_op == OP_SHL);
        end else if (r_state == ST_SHIFT) begin
            r_sh_data <= w_sh_next;
            r_sh_cnt  <= r_sh_cnt - REG_ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
            r_flags <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[w_wr_addr] <= w_wr_data;
            end
            r_flags <= w_flags_nxt;
        end
    end

    // A new STB/RDS on the draining edge reloads the buffer without a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_data_nxt;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire
